add_arbiter: RTL and testbench
==============================

# add_arbiter

Shares the datapath's single 32-bit combinational adder among up to NREQ requesters, such as the PC incrementer, branch-target unit and address generator. Uses round-robin arbitration. Each requester gets a valid/ready operand handshake. The block drives the adder inputs from internal registers and returns the captured sum, tagged with the requester index, over a valid/ready response channel. It sits between the requesting units and the adder instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- IDW, 2, requester-index width; must satisfy 2**IDW >= NREQ
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, packed the same way
- add_in1  out  WIDTH  to adder In1
- add_in2  out  WIDTH  to adder In2
- add_out  in  WIDTH  from adder OUT, combinational sum
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  sum
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_ovf  out  1  signed overflow flag; see Configuration

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. Reset state is IDLE.
- **IDLE:**
  - Scan requesters starting at ptr+1 mod NREQ and grant the first one with req_valid set.
  - req_ready[g] is combinational and asserted only in IDLE for the granted index g.
  - On the handshake: latch req_a[g] into op1, req_b[g] into op2 and g into gid; go to ISSUE.
  - With no valid requester, stay in IDLE.
- **ISSUE:**
  - add_in1 = op1, add_in2 = op2.
  - At the clock edge, capture add_out into rsp_data and gid into rsp_id; go to RESP.
- **RESP:**
  - rsp_valid = 1. rsp_data and rsp_id are held stable.
  - When rsp_ready = 1: ptr <= gid, go to IDLE.
- Requesters must hold req_a, req_b and req_valid stable until req_ready.
- Dropping req_valid before the grant is legal; the block then picks no one or another requester.
- Arithmetic is modulo 2**WIDTH. The carry-out is discarded.
- add_in1 and add_in2 hold op1 and op2 in every state; they change only at the handshake.
- Reset mid-operation in ISSUE or RESP discards the transaction. No response is produced and ptr reinitialises.

## Timing
- Reset values:
  - state = IDLE
  - ptr = NREQ-1, so requester 0 has first priority
  - op1 = op2 = 0
  - rsp_data = 0, rsp_id = 0, rsp_valid = 0, rsp_ovf = 0
  - req_ready = 0 during the reset cycle
- Latency: a handshake at edge T gives rsp_valid high in the cycle after edge T+1, i.e. 2 cycles.
- Throughput: at best one operation per 3 cycles, with rsp_ready held high.
- Backpressure: RESP persists indefinitely while rsp_ready = 0. No new grant is issued during that time.
- Simultaneous requests: round-robin order from the pointer. No requester waits more than NREQ-1 other grants.
- A requester that reasserts req_valid immediately after its own response has lowest priority in the next IDLE.

## Configuration
- ADD_ARBITER_OVF_EN
- **Defined:** rsp_ovf is registered alongside rsp_data in ISSUE as `(op1[MSB]==op2[MSB]) && (add_out[MSB]!=op1[MSB])`. It is held through RESP.
- **Undefined:** rsp_ovf is constant 0 and no overflow logic is synthesised.
- All other behaviour is identical in both builds.

## Test plan
- **Single request:** reset, then req_valid[0]=1 with a=1, b=3.
  - req_ready[0] is high in the first IDLE cycle.
  - 2 cycles later: rsp_valid=1, rsp_data=4, rsp_id=0.
- **Round-robin:** all four requesters valid simultaneously with operand pairs (10,6), (20,1), (7,7), (0,5), and rsp_ready=1.
  - Responses arrive in order id 0, 1, 2, 3 with sums 16, 21, 14, 5, spaced 3 cycles apart.
- **Backpressure:** rsp_ready=0 for 5 cycles after rsp_valid, while req_valid[1] is high.
  - rsp_data, rsp_id and rsp_valid stay stable and req_ready stays 0.
  - The grant to requester 1 occurs in the IDLE cycle after rsp_ready rises.
- **Wrap-around:** a=0xFFFF_FFFF, b=2.
  - rsp_data=1.
  - rsp_ovf=0 in both builds.
- **Overflow (ADD_ARBITER_OVF_EN defined):** a=0x7FFF_FFFF, b=1.
  - rsp_data=0x8000_0000, rsp_ovf=1.
  - With the macro undefined, rsp_ovf=0.
- **Reset mid-operation:** assert rst_n=0 for one cycle while in ISSUE.
  - No rsp_valid follows.
  - The next simultaneous requests from 0 and 2 grant requester 0 first.

Source files
------------

// File: rtl/add_arbiter_if.sv
// Operand request and result response channels between the requesting units and add_arbiter.
interface add_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin sharing of one combinational adder among NREQ requesters.
// Define ADD_ARBITER_OVF_EN to register a signed-overflow flag with each result.
module add_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  add_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  input  logic [WIDTH-1:0] add_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic             gnt_valid;
  logic [IDW-1:0]   gnt_idx;

  // First valid requester after the pointer wins; the previous winner is scanned last.
  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!gnt_valid && bus.req_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state_q == StIdle) && gnt_valid) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          op1_d   = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
          op2_d   = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
          gid_d   = gnt_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        rsp_data_d = add_out;
        rsp_id_d   = gid_q;
        state_d    = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          ptr_d   = gid_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IDW'(NREQ - 1);
      gid_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef ADD_ARBITER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StIssue) begin
      ovf_d = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (add_out[WIDTH-1] != op1_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.rsp_ovf = ovf_q;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

  assign add_in1       = op1_q;
  assign add_in2       = op2_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_add_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();
  logic [WIDTH-1:0] add_in1, add_in2, add_out;

  // Stand-in for the shared combinational adder.
  assign add_out = add_in1 + add_in2;

  add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .add_in1 (add_in1),
    .add_in2 (add_in2),
    .add_out (add_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (v[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic bit ovf_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef ADD_ARBITER_OVF_EN
    longint s, hi, lo;
    s  = longint'($signed(a)) + longint'($signed(b));
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    return (s > hi) || (s < lo);
`else
    return (a & b & 1'b0) != 0;
`endif
  endfunction

  bit               m_live = 1'b0;
  int               m_ptr, m_gid, m_id, m_age;
  bit               m_busy, m_ovf;
  logic [WIDTH-1:0] m_in1, m_in2, m_data;

  always @(posedge clk) begin : model
    int g;
    if (rst_n === 1'b0) begin
      m_live <= 1'b1;
      m_ptr  <= NREQ - 1;
      m_busy <= 1'b0;
      m_age  <= 0;
      m_gid  <= 0;
      m_in1  <= '0;
      m_in2  <= '0;
      m_data <= '0;
      m_id   <= 0;
      m_ovf  <= 1'b0;
    end else if (m_live) begin
      if (!m_busy) begin
        g = pick(m_ptr, bus.req_valid);
        if (g >= 0) begin
          m_busy <= 1'b1;
          m_age  <= 1;
          m_gid  <= g;
          m_in1  <= bus.req_a[g*WIDTH +: WIDTH];
          m_in2  <= bus.req_b[g*WIDTH +: WIDTH];
        end
      end else if (m_age == 1) begin
        m_age  <= 2;
        m_data <= m_in1 + m_in2;
        m_id   <= m_gid;
        m_ovf  <= ovf_of(m_in1, m_in2);
      end else if (bus.rsp_ready) begin
        m_busy <= 1'b0;
        m_ptr  <= m_gid;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] exp_ready;
    int g;
    if (m_live) begin
      exp_ready = '0;
      if (rst_n && !m_busy) begin
        g = pick(m_ptr, bus.req_valid);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_ready);
      chk("rsp_valid", bus.rsp_valid, m_busy && (m_age == 2));
      chk("rsp_data", bus.rsp_data, m_data);
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_ovf", bus.rsp_ovf, m_ovf);
      chk("add_in1", add_in1, m_in1);
      chk("add_in2", add_in2, m_in2);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [NREQ-1:0] hs_seen = '0;
  always @(negedge clk) hs_seen = bus.req_ready & bus.req_valid;

  // Advance one cycle and retire requests that completed their handshake at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~hs_seen;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_valid[i]           = 1'b1;
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 20) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    chk("rsp_timeout", bus.rsp_valid, 1'b1);
  endtask

  task automatic run_one(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] d, output int id, output logic o);
    int c;
    set_req(i, a, b);
    wait_rsp(c);
    d  = bus.rsp_data;
    id = int'(bus.rsp_id);
    o  = bus.rsp_ovf;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    unique case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int c, id, cnt, n;
    int ids[$], stamps[$];
    logic [WIDTH-1:0] d, sums[$], hold_data;
    logic o;
    logic [IDW-1:0] hold_id;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Single request, valid already high during reset.
    rst_n = 1'b0;
    set_req(0, 32'd1, 32'd3);
    @(negedge clk);
    chk("ready_in_reset", bus.req_ready, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    chk("single_ready", bus.req_ready, 4'b0001);
    tick();
    wait_rsp(c);
    chk("single_latency", c, 2);
    chk("single_data", bus.rsp_data, 32'd4);
    chk("single_id", bus.rsp_id, 2'd0);
    tick();

    // Round-robin from a fresh pointer.
    do_reset();
    set_req(0, 32'd10, 32'd6);
    set_req(1, 32'd20, 32'd1);
    set_req(2, 32'd7, 32'd7);
    set_req(3, 32'd0, 32'd5);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids.push_back(int'(bus.rsp_id));
        sums.push_back(bus.rsp_data);
        stamps.push_back(k);
      end
      tick();
    end
    chk("rr_count", ids.size(), 4);
    if (ids.size() == 4) begin
      chk("rr_id0", ids[0], 0);
      chk("rr_id1", ids[1], 1);
      chk("rr_id2", ids[2], 2);
      chk("rr_id3", ids[3], 3);
      chk("rr_sum0", sums[0], 32'd16);
      chk("rr_sum1", sums[1], 32'd21);
      chk("rr_sum2", sums[2], 32'd14);
      chk("rr_sum3", sums[3], 32'd5);
      for (int k = 1; k < 4; k++) chk("rr_spacing", stamps[k] - stamps[k-1], 3);
    end

    // Backpressure with requester 1 waiting.
    bus.rsp_ready = 1'b0;
    set_req(0, 32'd100, 32'd200);
    wait_rsp(c);
    hold_data = bus.rsp_data;
    hold_id   = bus.rsp_id;
    chk("bp_data", hold_data, 32'd300);
    tick();
    set_req(1, 32'd5, 32'd6);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== hold_data || bus.rsp_id !== hold_id ||
          bus.req_ready !== 4'b0000) cnt++;
      tick();
    end
    chk("bp_stable", cnt, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_grant1", bus.req_ready, 4'b0010);
    tick();
    wait_rsp(c);
    chk("bp_rsp_data", bus.rsp_data, 32'd11);
    chk("bp_rsp_id", bus.rsp_id, 2'd1);
    tick();

    // Wrap-around and signed overflow.
    run_one(2, 32'hFFFF_FFFF, 32'd2, d, id, o);
    chk("wrap_data", d, 32'd1);
    chk("wrap_ovf", o, 1'b0);
    run_one(3, 32'h7FFF_FFFF, 32'd1, d, id, o);
    chk("ovf_data", d, 32'h8000_0000);
`ifdef ADD_ARBITER_OVF_EN
    chk("ovf_flag", o, 1'b1);
`else
    chk("ovf_flag", o, 1'b0);
`endif

    // Reset while in ISSUE.
    set_req(1, 32'd9, 32'd9);
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
      tick();
    end
    chk("rst_no_rsp", cnt, 0);
    set_req(0, 32'd1, 32'd1);
    set_req(2, 32'd2, 32'd2);
    @(negedge clk);
    chk("rst_grant0", bus.req_ready, 4'b0001);
    for (int k = 0; k < 10; k++) tick();

    // Randomized traffic with legal early drops and random backpressure.
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, rand_op(), rand_op());
          n++;
        end else if (bus.req_valid[i] && $urandom_range(0, 49) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
